id_ex_stage_reg: RTL and testbench

Parametrised ID/EX pipeline register for the pipelined RISC-V core, the successor to the fixed-width ID/EX latch. It registers decoded operands and control, and decodes the EX/MEM M and WB control bundles from the ALU operation code. It adds a valid bit, stall/flush handling, load-use hazard detection with automatic bubble insertion, and saturating performance counters. It sits between the decode stage (register file, immediate generator, ALU control) and the execute stage (forwarding unit, ALU).

---
 rtl/id_ex_pkg.sv | 49 ++++
 rtl/id_ex_stage_reg_sat_counter.sv | 25 ++
 rtl/id_ex_stage_reg.sv | 157 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: operation codes, control
// bundle layout and the operation-to-control decode used by the EX/MEM/WB stages.
package id_ex_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int REGW_DEF  = 5;
  localparam int OPW_DEF   = 4;
  localparam int CNT_W_DEF = 16;

  localparam logic [3:0] OP_ALU_0 = 4'b0000;
  localparam logic [3:0] OP_ALU_1 = 4'b0001;
  localparam logic [3:0] OP_ALU_2 = 4'b0010;
  localparam logic [3:0] OP_ALU_3 = 4'b0011;
  localparam logic [3:0] OP_ALU_4 = 4'b0100;
  localparam logic [3:0] OP_LD    = 4'b0101;
  localparam logic [3:0] OP_SD    = 4'b0110;
  localparam logic [3:0] OP_BEQ   = 4'b0111;
  localparam logic [3:0] OP_ALU_8 = 4'b1000;

  localparam int M_READ      = 2;
  localparam int M_WRITE     = 1;
  localparam int M_BRANCH    = 0;
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  typedef struct packed {
    logic [2:0] m;   // {MemRead, MemWrite, Branch}
    logic [1:0] wb;  // {MemtoReg, RegWrite}
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [3:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_ALU_0, OP_ALU_1, OP_ALU_2, OP_ALU_3, OP_ALU_4, OP_ALU_8:
        c.wb[WB_REGWRITE] = 1'b1;
      OP_LD: begin
        c.m[M_READ]        = 1'b1;
        c.wb[WB_MEMTOREG]  = 1'b1;
        c.wb[WB_REGWRITE]  = 1'b1;
      end
      OP_SD:   c.m[M_WRITE]  = 1'b1;
      OP_BEQ:  c.m[M_BRANCH] = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_sat_counter.sv
// Saturating up-counter: increments on inc_i and sticks at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush, load-use bubble insertion
// and saturating bubble/stall performance counters.
module id_ex_stage_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int OPW   = OPW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  instr_i,
  input  logic [OPW-1:0]   operation_i,
  input  logic             alu_src_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  instr_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [OPW-1:0]   operation_o,
  output logic             alu_src_o,
  output logic [REGW-1:0]  rs1_addr_o,
  output logic [REGW-1:0]  rs2_addr_o,
  output logic [REGW-1:0]  rd_addr_o,
  output logic [2:0]       ex_mem_m_o,
  output logic [1:0]       ex_mem_wb_o,
  output logic             hazard_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic            valid_q,    valid_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] instr_q,    instr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [OPW-1:0]  op_q,       op_d;
  logic            alu_src_q,  alu_src_d;
  logic [REGW-1:0] rs1_addr_q, rs1_addr_d;
  logic [REGW-1:0] rs2_addr_q, rs2_addr_d;
  logic [REGW-1:0] rd_addr_q,  rd_addr_d;
  ctrl_t           ctrl_q,     ctrl_d;

  logic [REGW-1:0] id_rs1, id_rs2;
  logic            hazard;

  assign id_rs1 = REGW'(instr_i[19:15]);
  assign id_rs2 = REGW'(instr_i[24:20]);

  // Load in EX whose destination is read by the instruction now in ID.
  assign hazard = valid_q & ctrl_q.m[M_READ] & (rd_addr_q != '0) & id_valid_i &
                  ((rd_addr_q == id_rs1) | (rd_addr_q == id_rs2));

  // NOTE: every next-state signal defaults to its current value before any
  // branch, so no path leaves a combinational output unassigned (no latches).
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    op_d       = op_q;
    alu_src_d  = alu_src_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    ctrl_d     = ctrl_q;
    if (flush_i || (!stall_i && hazard)) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (!stall_i) begin
      valid_d    = id_valid_i;
      pc_d       = pc_i;
      instr_d    = instr_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      op_d       = operation_i;
      alu_src_d  = alu_src_i;
      rs1_addr_d = id_rs1;
      rs2_addr_d = id_rs2;
      rd_addr_d  = REGW'(instr_i[11:7]);
      ctrl_d     = id_valid_i ? decode_ctrl(4'(operation_i)) : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      instr_q    <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      op_q       <= '0;
      alu_src_q  <= 1'b0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      ctrl_q     <= '0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      op_q       <= op_d;
      alu_src_q  <= alu_src_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      ctrl_q     <= ctrl_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (hazard & ~stall_i & ~flush_i),
    .count_o (bubble_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (stall_i & ~flush_i),
    .count_o (stall_cnt_o)
  );

  assign valid_o     = valid_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign rs1_data_o  = rs1_data_q;
  assign rs2_data_o  = rs2_data_q;
  assign imm_o       = imm_q;
  assign operation_o = op_q;
  assign alu_src_o   = alu_src_q;
  assign rs1_addr_o  = rs1_addr_q;
  assign rs2_addr_o  = rs2_addr_q;
  assign rd_addr_o   = rd_addr_q;
  assign ex_mem_m_o  = ctrl_q.m;
  assign ex_mem_wb_o = ctrl_q.wb;
  assign hazard_o    = hazard;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed vectors push the outputs expected
// while each vector is applied; a monitor on the falling edge pops and compares.
module tb_id_ex_stage_reg;

  localparam int XLEN = 32, REGW = 5, OPW = 4, CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [XLEN-1:0]  pc = '0, instr = '0, rs1_data = '0, rs2_data = '0, imm = '0;
  logic [OPW-1:0]   operation = '0;
  logic             alu_src = 1'b0, stall = 1'b0, flush = 1'b0;
  logic             valid_o, alu_src_o, hazard_o;
  logic [XLEN-1:0]  pc_o, instr_o, rs1_data_o, rs2_data_o, imm_o;
  logic [OPW-1:0]   operation_o;
  logic [REGW-1:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [2:0]       m_o;
  logic [1:0]       wb_o;
  logic [CNT_W-1:0] bubble_cnt_o, stall_cnt_o;

  id_ex_stage_reg #(.XLEN(XLEN), .REGW(REGW), .OPW(OPW), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_n), .id_valid_i(id_valid), .pc_i(pc), .instr_i(instr),
    .operation_i(operation), .alu_src_i(alu_src), .rs1_data_i(rs1_data),
    .rs2_data_i(rs2_data), .imm_i(imm), .stall_i(stall), .flush_i(flush),
    .valid_o(valid_o), .pc_o(pc_o), .instr_o(instr_o), .rs1_data_o(rs1_data_o),
    .rs2_data_o(rs2_data_o), .imm_o(imm_o), .operation_o(operation_o),
    .alu_src_o(alu_src_o), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rd_addr_o(rd_addr_o), .ex_mem_m_o(m_o), .ex_mem_wb_o(wb_o), .hazard_o(hazard_o),
    .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            rst, idv, stall, flush;
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1, rs2, rd;
    logic [3:0]      op;
    // outputs expected while this vector is applied
    logic            ev, eh;
    logic [2:0]      em;
    logic [1:0]      ewb;
    logic [XLEN-1:0] epc;
    logic [4:0]      erd;
    logic [1:0]      ebc, esc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int compared = 0;
  int mismatched = 0;

  function automatic logic [XLEN-1:0] mk_instr(input logic [4:0] rs1, rs2, rd);
    return {7'd0, rs2, rs1, 3'd0, rd, 7'h33};
  endfunction

  // Data fields are driven as pc + offset, so the expected copy follows the held pc.
  function automatic logic [XLEN-1:0] exp_data(input logic [XLEN-1:0] epc,
                                               input logic [XLEN-1:0] off);
    return (epc == '0) ? '0 : epc + off;
  endfunction

  task automatic add(input logic rst, idv, stall, flush, input logic [XLEN-1:0] p,
                     input logic [4:0] rs1, rs2, rd, input logic [3:0] op,
                     input logic ev, eh, input logic [2:0] em, input logic [1:0] ewb,
                     input logic [XLEN-1:0] epc, input logic [4:0] erd,
                     input logic [1:0] ebc, esc);
    vec_t v;
    v.rst = rst; v.idv = idv; v.stall = stall; v.flush = flush; v.pc = p;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.op = op;
    v.ev = ev; v.eh = eh; v.em = em; v.ewb = ewb; v.epc = epc; v.erd = erd;
    v.ebc = ebc; v.esc = esc;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [XLEN-1:0] act, exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      vec_t e;
      e = sb.pop_front();
      check("valid",   XLEN'(valid_o),      XLEN'(e.ev));
      check("hazard",  XLEN'(hazard_o),     XLEN'(e.eh));
      check("m",       XLEN'(m_o),          XLEN'(e.em));
      check("wb",      XLEN'(wb_o),         XLEN'(e.ewb));
      check("pc",      pc_o,                e.epc);
      check("rd_addr", XLEN'(rd_addr_o),    XLEN'(e.erd));
      check("bub_cnt", XLEN'(bubble_cnt_o), XLEN'(e.ebc));
      check("stl_cnt", XLEN'(stall_cnt_o),  XLEN'(e.esc));
      check("rs1_data", rs1_data_o, exp_data(e.epc, 32'h1000));
      check("imm",      imm_o,      exp_data(e.epc, 32'h3000));
    end
  end

  initial begin
    // rst idv stl fl pc        rs1 rs2 rd  op       | v  h  m      wb     pc        rd  bc sc
    add(0, 0, 0, 0, 32'h000,  0,  0,  0, 4'b0000,  0, 0, 3'b000, 2'b00, 32'h000,  0, 0, 0);
    // decode sweep: ld, sd, beq, alu, unknown
    add(1, 1, 0, 0, 32'h100,  1,  2,  5, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h000,  0, 0, 0);
    add(1, 1, 0, 0, 32'h104,  6,  7,  8, 4'b0110,  1, 0, 3'b100, 2'b11, 32'h100,  5, 0, 0);
    add(1, 1, 0, 0, 32'h108,  5,  5,  9, 4'b0111,  1, 0, 3'b010, 2'b00, 32'h104,  8, 0, 0);
    add(1, 1, 0, 0, 32'h10C,  1,  2, 10, 4'b0010,  1, 0, 3'b001, 2'b00, 32'h108,  9, 0, 0);
    add(1, 1, 0, 0, 32'h110,  1,  2, 11, 4'b1111,  1, 0, 3'b000, 2'b01, 32'h10C, 10, 0, 0);
    // load-use on x5: hazard, one bubble, then dependent loads
    add(1, 1, 0, 0, 32'h114,  1,  2,  5, 4'b0101,  1, 0, 3'b000, 2'b00, 32'h110, 11, 0, 0);
    add(1, 1, 0, 0, 32'h118,  5,  3, 12, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h114,  5, 0, 0);
    add(1, 1, 0, 0, 32'h118,  5,  3, 12, 4'b0000,  0, 0, 3'b000, 2'b00, 32'h114,  5, 1, 0);
    // ld to x0 followed by a reader of x0: no hazard
    add(1, 1, 0, 0, 32'h11C,  1,  2,  0, 4'b0101,  1, 0, 3'b000, 2'b01, 32'h118, 12, 1, 0);
    add(1, 1, 0, 0, 32'h120,  0,  0, 13, 4'b0000,  1, 0, 3'b100, 2'b11, 32'h11C,  0, 1, 0);
    // flush with stall and hazard active: no counter moves
    add(1, 1, 0, 0, 32'h124,  1,  2,  6, 4'b0101,  1, 0, 3'b000, 2'b01, 32'h120, 13, 1, 0);
    add(1, 1, 1, 1, 32'h128,  3,  6, 14, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h124,  6, 1, 0);
    add(1, 1, 0, 0, 32'h12C,  1,  2, 15, 4'b0000,  0, 0, 3'b000, 2'b00, 32'h124,  6, 1, 0);
    // three stall cycles with changing inputs
    add(1, 1, 1, 0, 32'h130,  1,  2, 16, 4'b0101,  1, 0, 3'b000, 2'b01, 32'h12C, 15, 1, 0);
    add(1, 1, 1, 0, 32'h134,  1,  2, 17, 4'b0110,  1, 0, 3'b000, 2'b01, 32'h12C, 15, 1, 1);
    add(1, 1, 1, 0, 32'h138,  1,  2, 18, 4'b0111,  1, 0, 3'b000, 2'b01, 32'h12C, 15, 1, 2);
    add(1, 1, 0, 0, 32'h13C,  1,  2, 19, 4'b0000,  1, 0, 3'b000, 2'b01, 32'h12C, 15, 1, 3);
    // five load-use pairs: bubble counter saturates at 3
    add(1, 1, 0, 0, 32'h140,  1,  2, 20, 4'b0101,  1, 0, 3'b000, 2'b01, 32'h13C, 19, 1, 3);
    add(1, 1, 0, 0, 32'h144, 20,  1, 21, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h140, 20, 1, 3);
    add(1, 1, 0, 0, 32'h148,  1,  2, 22, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h140, 20, 2, 3);
    add(1, 1, 0, 0, 32'h14C,  1, 22, 23, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h148, 22, 2, 3);
    add(1, 1, 0, 0, 32'h150,  1,  2, 24, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h148, 22, 3, 3);
    add(1, 1, 0, 0, 32'h154, 24,  0, 25, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h150, 24, 3, 3);
    add(1, 1, 0, 0, 32'h158,  1,  2, 26, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h150, 24, 3, 3);
    add(1, 1, 0, 0, 32'h15C, 26, 26, 27, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h158, 26, 3, 3);
    add(1, 1, 0, 0, 32'h160,  1,  2, 28, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h158, 26, 3, 3);
    add(1, 1, 0, 0, 32'h164, 28,  3, 29, 4'b0000,  1, 1, 3'b100, 2'b11, 32'h160, 28, 3, 3);
    add(1, 1, 0, 0, 32'h168,  1,  2, 30, 4'b0000,  0, 0, 3'b000, 2'b00, 32'h160, 28, 3, 3);
    // reset dropped mid-cycle clears at once; first edge after release loads
    add(0, 1, 0, 0, 32'h16C,  1,  2, 31, 4'b0101,  0, 0, 3'b000, 2'b00, 32'h000,  0, 0, 0);
    add(1, 1, 0, 0, 32'h170,  1,  2,  7, 4'b0110,  0, 0, 3'b000, 2'b00, 32'h000,  0, 0, 0);
    add(1, 0, 0, 0, 32'h174,  7,  7,  1, 4'b0101,  1, 0, 3'b010, 2'b00, 32'h170,  7, 0, 0);
    add(1, 0, 0, 0, 32'h178,  1,  2,  3, 4'b0000,  0, 0, 3'b000, 2'b00, 32'h174,  1, 0, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #2;
      rst_n     = vecs[i].rst;
      id_valid  = vecs[i].idv;
      stall     = vecs[i].stall;
      flush     = vecs[i].flush;
      pc        = vecs[i].pc;
      instr     = mk_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd);
      operation = vecs[i].op;
      alu_src   = vecs[i].pc[2];
      rs1_data  = vecs[i].pc + 32'h1000;
      rs2_data  = vecs[i].pc + 32'h2000;
      imm       = vecs[i].pc + 32'h3000;
      sb.push_back(vecs[i]);
    end

    for (int n = 0; n < 5 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
